// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer
// Buffers {J,K} drive commands in a small FIFO and plays each one onto the
// J/K pins of a downstream JK flip-flop for cmd_count+1 cycles. Commands run
// back-to-back with no idle cycle between them. done pulses on the last
// drive cycle of every command.
//
// Optional feature: define JK_DRV_CHECK_EN to build an expected-Q model.
// The model compares against q_in and raises a sticky mismatch flag. Without
// the macro, q_in is ignored and mismatch is tied low.
//
// FIFO_DEPTH must be a power of two and at least 2, so that the pointers can
// wrap naturally.

module jk_drive_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_count,
    output logic       J,
    output logic       K,
    output logic       busy,
    output logic       done,
    input  logic       q_in,
    output logic       mismatch
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    logic [1:0]    op_mem  [FIFO_DEPTH];
    logic [3:0]    cnt_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill;

    state_t        state;
    logic [3:0]    remain;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          last_cycle;

    assign fifo_empty = (fill == '0);
    assign cmd_ready  = (fill != (AW+1)'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign last_cycle = (state == DRIVE) && (remain == 4'd0);
    assign pop        = !fifo_empty && ((state == IDLE) || last_cycle);

    // Command storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= cmd_op;
            cnt_mem[wr_ptr] <= cmd_count;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Drive FSM: load on pop, count down in DRIVE, registered J/K/busy/done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            remain <= 4'd0;
            J      <= 1'b0;
            K      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (pop) begin
            state  <= DRIVE;
            remain <= cnt_mem[rd_ptr];
            J      <= op_mem[rd_ptr][1];
            K      <= op_mem[rd_ptr][0];
            busy   <= 1'b1;
            done   <= (cnt_mem[rd_ptr] == 4'd0);
        end else if ((state == DRIVE) && (remain != 4'd0)) begin
            remain <= remain - 4'd1;
            done   <= (remain == 4'd1);
        end else if (last_cycle) begin
            state  <= IDLE;
            J      <= 1'b0;
            K      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done   <= 1'b0;
        end
    end

`ifdef JK_DRV_CHECK_EN
    logic exp_q;

    // Mirror the downstream flop from our own J/K and flag any divergence of q_in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   exp_q <= 1'b0;
                2'b10:   exp_q <= 1'b1;
                2'b11:   exp_q <= ~exp_q;
                default: exp_q <= exp_q;
            endcase
            if (q_in != exp_q) begin
                mismatch <= 1'b1;
            end
        end
    end
`else
    logic unused_q_in;

    assign unused_q_in = q_in;
    assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Testbench for jk_drive_sequencer.
// A scoreboard queue receives one {J,K,done} entry per expected drive cycle
// whenever a command is accepted. A negedge monitor pops and compares the
// queue while the DUT is busy, and checks mismatch every cycle. Each test
// task adds its own timing-specific comparisons.
// Build with +define+JK_DRV_CHECK_EN to exercise the Q-check model.

module tb_jk_drive_sequencer;

    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_count = 4'd0;
    logic       cmd_ready;
    logic       J;
    logic       K;
    logic       busy;
    logic       done;
    logic       q_in;
    logic       mismatch;

    logic       q_model = 1'b0;
    logic       q_flip = 1'b0;
    logic       exp_mismatch = 1'b0;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [2:0] sb[$];

    jk_drive_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .J         (J),
        .K         (K),
        .busy      (busy),
        .done      (done),
        .q_in      (q_in),
        .mismatch  (mismatch)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    assign q_in = q_model ^ q_flip;

    // Behavioural downstream JK flip-flop driven by the DUT
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_model <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   q_model <= 1'b0;
                2'b10:   q_model <= 1'b1;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase
        end
    end

`ifndef JK_DRV_CHECK_EN
    // Without the check model, q_in is random noise that must be ignored
    always @(negedge clk) begin
        q_flip <= 1'($urandom_range(0, 1));
    end
`endif

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [2:0] exp_v;
        if (!reset) begin
            n_checks++;
            if (busy) begin
                if (sb.size() == 0) begin
                    $display("[TB] FAIL drive_underflow: busy=1 J=%b K=%b with no expected cycle queued", J, K);
                end else begin
                    exp_v = sb.pop_front();
                    if ({J, K, done} !== exp_v) begin
                        $display("[TB] FAIL drive_cycle: {J,K,done} got %b expected %b at %0t", {J, K, done}, exp_v, $time);
                    end else begin
                        n_pass++;
                    end
                end
            end else begin
                if ({J, K, done} !== 3'b000) begin
                    $display("[TB] FAIL idle_outputs: {J,K,done} got %b expected 000 at %0t", {J, K, done}, $time);
                end else begin
                    n_pass++;
                end
            end
            n_checks++;
            if (mismatch !== exp_mismatch) begin
                $display("[TB] FAIL mismatch_flag: got %b expected %b at %0t", mismatch, exp_mismatch, $time);
            end else begin
                n_pass++;
            end
        end
    end

    // Offer one command, wait for acceptance, queue its expected drive cycles
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] cnt, output int waited);
        logic acc;
        acc       = 1'b0;
        waited    = 0;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        while (!acc && waited < 64) begin
            acc = cmd_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            $display("[TB] FAIL accept_timeout: op=%b count=%0d not accepted after %0d edges", op, cnt, waited);
        end else begin
            n_pass++;
            for (int i = 0; i <= int'(cnt); i++) begin
                sb.push_back({op, (i == int'(cnt))});
            end
        end
    endtask

    // Wait until every queued drive cycle has been observed and the FSM is idle
    task automatic drain(output bit ok);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = !busy && (sb.size() == 0);
    endtask

    // Pulse reset across one clock edge and restart the scoreboard
    task automatic applyStimulus_reset();
        #2;
        reset = 1'b1;
        sb.delete();
        exp_mismatch = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({J, K, busy, done, mismatch} !== 5'b00000) begin
            $display("[TB] FAIL reset_outputs: {J,K,busy,done,mismatch} got %b expected 00000", {J, K, busy, done, mismatch});
        end else begin
            n_pass++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready);
        end else begin
            n_pass++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int w;
        bit ok;
        send_cmd(2'b10, 4'd2, w);
        n_checks++;
        if ({J, K, busy} !== 3'b000) begin
            $display("[TB] FAIL single_latency: {J,K,busy} after accept edge got %b expected 000", {J, K, busy});
        end else begin
            n_pass++;
        end
        for (int e = 2; e <= 4; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({J, K, busy, done} !== {3'b101, (e == 4)}) begin
                $display("[TB] FAIL single_edge%0d: {J,K,busy,done} got %b expected %b", e, {J, K, busy, done}, {3'b101, (e == 4)});
            end else begin
                n_pass++;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({J, K, busy, done} !== 4'b0000) begin
            $display("[TB] FAIL single_end: {J,K,busy,done} got %b expected 0000", {J, K, busy, done});
        end else begin
            n_pass++;
        end
        drain(ok);
        n_checks++;
        if (!ok) begin
            $display("[TB] FAIL single_drain: busy=%b queued=%0d expected idle and empty", busy, sb.size());
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int w;
        bit ok;
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b1111;
        exp_seq[1] = 4'b0110;
        exp_seq[2] = 4'b0111;
        send_cmd(2'b11, 4'd0, w);
        send_cmd(2'b01, 4'd1, w);
        for (int c = 0; c < 3; c++) begin
            if (c != 0) begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if ({J, K, busy, done} !== exp_seq[c]) begin
                $display("[TB] FAIL b2b_cycle%0d: {J,K,busy,done} got %b expected %b", c, {J, K, busy, done}, exp_seq[c]);
            end else begin
                n_pass++;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({J, K, busy, done} !== 4'b0000) begin
            $display("[TB] FAIL b2b_end: {J,K,busy,done} got %b expected 0000", {J, K, busy, done});
        end else begin
            n_pass++;
        end
        drain(ok);
        n_checks++;
        if (!ok) begin
            $display("[TB] FAIL b2b_drain: busy=%b queued=%0d expected idle and empty", busy, sb.size());
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int w;
        bit ok;
        logic [1:0] ops [5];
        logic [3:0] cnts [5];
        ops[0] = 2'b11; cnts[0] = 4'd0;
        ops[1] = 2'b01; cnts[1] = 4'd1;
        ops[2] = 2'b10; cnts[2] = 4'd2;
        ops[3] = 2'b11; cnts[3] = 4'd0;
        ops[4] = 2'b01; cnts[4] = 4'd1;
        send_cmd(2'b10, 4'd15, w);
        for (int i = 0; i < 4; i++) begin
            send_cmd(ops[i], cnts[i], w);
        end
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            $display("[TB] FAIL bp_full_ready: got %b expected 0 with %0d buffered", cmd_ready, FIFO_DEPTH);
        end else begin
            n_pass++;
        end
        send_cmd(ops[4], cnts[4], w);
        n_checks++;
        if (w != 14) begin
            $display("[TB] FAIL bp_fifth_wait: accepted after %0d edges expected 14", w);
        end else begin
            n_pass++;
        end
        drain(ok);
        n_checks++;
        if (!ok) begin
            $display("[TB] FAIL bp_drain: busy=%b queued=%0d expected idle and empty", busy, sb.size());
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int w;
        bit stray;
        send_cmd(2'b11, 4'd7, w);
        send_cmd(2'b10, 4'd1, w);
        send_cmd(2'b01, 4'd0, w);
        @(posedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        exp_mismatch = 1'b0;
        #1;
        n_checks++;
        if ({J, K, busy, done, cmd_ready} !== 5'b00001) begin
            $display("[TB] FAIL mid_reset_outputs: {J,K,busy,done,ready} got %b expected 00001", {J, K, busy, done, cmd_ready});
        end else begin
            n_pass++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (busy || done) begin
                stray = 1'b1;
            end
        end
        n_checks++;
        if (stray !== 1'b0) begin
            $display("[TB] FAIL mid_reset_flush: activity seen got %b expected 0", stray);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_q_check();
        int w;
        bit ok;
        applyStimulus_reset();
        send_cmd(2'b11, 4'd3, w);
        drain(ok);
        n_checks++;
        if (mismatch !== 1'b0) begin
            $display("[TB] FAIL qchk_clean: mismatch got %b expected 0", mismatch);
        end else begin
            n_pass++;
        end
`ifdef JK_DRV_CHECK_EN
        send_cmd(2'b11, 4'd3, w);
        @(posedge clk);
        #1;
        q_flip = 1'b1;
        @(posedge clk);
        #1;
        q_flip = 1'b0;
        exp_mismatch = 1'b1;
        n_checks++;
        if (mismatch !== 1'b1) begin
            $display("[TB] FAIL qchk_detect: mismatch got %b expected 1", mismatch);
        end else begin
            n_pass++;
        end
        drain(ok);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (mismatch !== 1'b1) begin
            $display("[TB] FAIL qchk_sticky: mismatch got %b expected 1", mismatch);
        end else begin
            n_pass++;
        end
        #2;
        reset = 1'b1;
        exp_mismatch = 1'b0;
        #1;
        n_checks++;
        if (mismatch !== 1'b0) begin
            $display("[TB] FAIL qchk_reset: mismatch got %b expected 0", mismatch);
        end else begin
            n_pass++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
`else
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (mismatch !== 1'b0) begin
            $display("[TB] FAIL qchk_disabled: mismatch got %b expected 0", mismatch);
        end else begin
            n_pass++;
        end
`endif
    endtask

    // Overall time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_q_check();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jk_drive_sequencer.md
JK_DRIVE_SEQUENCER -- requirements
Module: jk_drive_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, the command buffer depth; it SHALL be a power of 2 and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: a command can be accepted.
REQ-006 The block SHALL have port cmd_op, input, 2 bits: {J,K} code; 00 hold, 01 clear, 10 set, 11 toggle.
REQ-007 The block SHALL have port cmd_count, input, 4 bits: repeat count; the op is driven for cmd_count+1 cycles.
REQ-008 The block SHALL have ports J and K, outputs, 1 bit each, registered: drive the downstream JK flip-flop.
REQ-009 The block SHALL have port busy, output, 1 bit: the FSM is in DRIVE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse on the last drive cycle of each command.
REQ-011 The block SHALL have port q_in, input, 1 bit: Q fed back from the downstream flip-flop; it is used only with JK_DRV_CHECK_EN.
REQ-012 The block SHALL have port mismatch, output, 1 bit: sticky Q-check error flag.

Function
REQ-013 Handshake: a command SHALL be accepted on any rising edge where cmd_valid and cmd_ready are both 1; cmd_op and cmd_count are then written into the FIFO.
REQ-014 cmd_ready SHALL equal "FIFO not full". A pop in the same cycle SHALL NOT raise cmd_ready while the FIFO is full.
REQ-015 FSM states SHALL be IDLE and DRIVE.
  - IDLE with the FIFO non-empty: pop the head on the next edge, load J,K from the op and the remaining counter from cmd_count, then go to DRIVE.
  - IDLE with the FIFO empty: stay in IDLE, J=K=0.
REQ-016 In DRIVE, the counter SHALL decrement once per cycle while J,K stay at the op. The cycle where the counter is 0 SHALL be the last drive cycle, and done SHALL be 1 in that cycle.
REQ-017 On the last drive cycle:
  - FIFO non-empty: the next command SHALL be popped and loaded on the following edge with no idle bubble (back-to-back).
  - FIFO empty: go to IDLE with J=K=0.
REQ-018 Latency: a command accepted at edge N with the FSM in IDLE and the FIFO empty SHALL appear on J,K after edge N+1.
REQ-019 A push and a pop in the same cycle SHALL both take effect. Occupancy SHALL stay unchanged, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 busy SHALL be 1 exactly while in DRIVE.
REQ-021 Commands SHALL execute in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-022 While reset is 1, the block SHALL hold: state IDLE, J=0, K=0, busy=0, done=0, mismatch=0, FIFO empty, cmd_ready=1, counter 0, expected-Q 0.
REQ-023 Reset asserted mid-command SHALL abort the command immediately and flush the FIFO. No done pulse SHALL be produced for the aborted command.

Configuration
REQ-024 With macro JK_DRV_CHECK_EN defined, the block SHALL keep an expected-Q model.
  - The model SHALL reset to 0.
  - On every edge it SHALL apply the JK rule (00 keep, 01 to 0, 10 to 1, 11 invert) using the current J,K, mirroring the downstream flop.
  - mismatch SHALL be set on any edge where q_in differs from the expected Q, and SHALL stay 1 until reset.
REQ-025 With JK_DRV_CHECK_EN undefined, the model SHALL be absent, q_in SHALL be ignored, and mismatch SHALL be tied to 0.

Verification
REQ-026 Single command: after reset, push op=10, count=2 at edge 1. Required: J=1, K=0 for edges 2-4; done=1 in the cycle after edge 4; J=K=0 and busy=0 after edge 5.
REQ-027 Back-to-back commands: push op=11 count=0, then op=01 count=1 on consecutive edges. Required: J,K = 11 for one cycle, then 01 for two cycles, with no 00 gap; done pulses twice.
REQ-028 Backpressure with FIFO_DEPTH=4: hold an active command with count=15 and push 5 more. Required: cmd_ready=0 after 4 buffered; the 5th is held until a pop frees a slot; all execute in order.
REQ-029 Reset mid-operation: assert reset during a count=7 command with 2 queued. Required: immediately J=K=0, busy=0, cmd_ready=1; no further done pulses.
REQ-030 With JK_DRV_CHECK_EN, toggle command count=3:
  - q_in from a correct JK flop: mismatch stays 0.
  - Force q_in wrong for one cycle: mismatch=1 and stays 1 until reset.
REQ-031 Without JK_DRV_CHECK_EN: any q_in pattern. Required: mismatch=0 throughout.
